gc_gate_sched: RTL

- Sequences one GC_engine instance through a garbled-circuit netlist, one gate at a time.
- For each gate it fetches a gate descriptor, reads both input labels from the label RAM, drives the engine and writes out_label back to the label RAM.
- It streams each gate's garbled table (t0, t1) to the host/MAC interface over a valid/ready handshake.
- It sits between the gate/label memories and GC_engine; R and AES_key go straight to the engine and are not touched here.

---
 rtl/gc_pkg.sv | 30 +++
 rtl/gc_gate_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gc_pkg.sv
// Shared types and constants for the garbled-circuit gate scheduler.
package gc_pkg;

  localparam int          CONST_OFS  = 2;
  localparam logic [3:0]  XOR_LOGIC  = 4'b0110;
  localparam logic [3:0]  XNOR_LOGIC = 4'b1001;
  // Wire-index width the gate descriptor is packed with; the scheduler's WA must match.
  localparam int          GC_WA      = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FG   = 3'd1,
    FL   = 3'd2,
    EV   = 3'd3,
    WB   = 3'd4,
    TX   = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic [GC_WA-1:0] in0_idx;
    logic [GC_WA-1:0] in1_idx;
    logic [3:0]       g_logic;
  } gate_desc_t;

  function automatic logic is_free_gate(input logic [3:0] g_logic);
    return (g_logic == XOR_LOGIC) || (g_logic == XNOR_LOGIC);
  endfunction

endpackage

// File: rtl/gc_gate_sched.sv
// Walks a garbled-circuit netlist one gate at a time around an external GC_engine.
// Build option GC_FREE_XOR_EN: XOR/XNOR gates write their label but stream no table.
//
// state | meaning
// IDLE  | waiting for start
// FG    | gate descriptor read address out
// FL    | descriptor back; input label reads issued
// EV    | input labels registered onto the engine
// WB    | engine result written to label RAM; table captured
// TX    | table offered on the stream until accepted
// DONE  | one-cycle completion pulse
module gc_gate_sched
  import gc_pkg::*;
#(
  parameter int K  = 128,
  parameter int S  = 20,
  parameter int WA = GC_WA,
  parameter int GA = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GA-1:0]     num_gates,
  input  logic [WA-1:0]     num_in,
  input  logic [S-1:0]      cid_in,
  output logic              busy,
  output logic              done,
  output logic [GA-1:0]     gate_raddr,
  input  logic [2*WA+3:0]   gate_rdata,
  output logic [WA-1:0]     lbl_raddr0,
  output logic [WA-1:0]     lbl_raddr1,
  input  logic [K-1:0]      lbl_rdata0,
  input  logic [K-1:0]      lbl_rdata1,
  output logic              lbl_we,
  output logic [WA-1:0]     lbl_waddr,
  output logic [K-1:0]      lbl_wdata,
  output logic [S-1:0]      eng_cid,
  output logic [S-1:0]      eng_gid,
  output logic [3:0]        eng_g_logic,
  output logic [K-1:0]      eng_in0_label,
  output logic [K-1:0]      eng_in1_label,
  input  logic [K-1:0]      eng_t0,
  input  logic [K-1:0]      eng_t1,
  input  logic [K-1:0]      eng_out_label,
  output logic              tbl_valid,
  input  logic              tbl_ready,
  output logic [K-1:0]      tbl_t0,
  output logic [K-1:0]      tbl_t1,
  output logic [GA-1:0]     tbl_gid
);

`ifdef GC_FREE_XOR_EN
  localparam logic FREE_XOR = 1'b1;
`else
  localparam logic FREE_XOR = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [GA-1:0]     g_q, g_d;
  logic [GA-1:0]     num_gates_q, num_gates_d;
  logic [WA-1:0]     num_in_q, num_in_d;
  logic [S-1:0]      cid_q, cid_d;
  logic [3:0]        logic_q, logic_d;
  logic [K-1:0]      eng_in0_q, eng_in0_d;
  logic [K-1:0]      eng_in1_q, eng_in1_d;
  logic [3:0]        eng_logic_q, eng_logic_d;
  logic [S-1:0]      eng_gid_q, eng_gid_d;
  logic [K-1:0]      tbl_t0_q, tbl_t0_d;
  logic [K-1:0]      tbl_t1_q, tbl_t1_d;
  logic [GA-1:0]     tbl_gid_q, tbl_gid_d;
  logic              tbl_valid_q, tbl_valid_d;

  gate_desc_t        rd_desc;
  logic              last_gate;
  logic              skip_tbl;

  assign rd_desc   = gate_desc_t'(gate_rdata);
  assign last_gate = (g_q == num_gates_q - GA'(1));
  assign skip_tbl  = FREE_XOR && is_free_gate(eng_logic_q);

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    num_gates_d = num_gates_q;
    num_in_d    = num_in_q;
    cid_d       = cid_q;
    logic_d     = logic_q;
    eng_in0_d   = eng_in0_q;
    eng_in1_d   = eng_in1_q;
    eng_logic_d = eng_logic_q;
    eng_gid_d   = eng_gid_q;
    tbl_t0_d    = tbl_t0_q;
    tbl_t1_d    = tbl_t1_q;
    tbl_gid_d   = tbl_gid_q;
    tbl_valid_d = tbl_valid_q;
    gate_raddr  = '0;
    lbl_raddr0  = '0;
    lbl_raddr1  = '0;
    lbl_we      = 1'b0;
    lbl_waddr   = '0;
    lbl_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_gates != '0) begin
            num_gates_d = num_gates;
            num_in_d    = num_in;
            cid_d       = cid_in;
            g_d         = '0;
            state_d     = FG;
          end else begin
            state_d = DONE;
          end
        end
      end
      FG: begin
        gate_raddr = g_q;
        state_d    = FL;
      end
      FL: begin
        logic_d    = rd_desc.g_logic;
        lbl_raddr0 = rd_desc.in0_idx + WA'(CONST_OFS);
        lbl_raddr1 = rd_desc.in1_idx + WA'(CONST_OFS);
        state_d    = EV;
      end
      EV: begin
        eng_in0_d   = lbl_rdata0;
        eng_in1_d   = lbl_rdata1;
        eng_logic_d = logic_q;
        eng_gid_d   = S'(g_q);
        state_d     = WB;
      end
      WB: begin
        lbl_we    = 1'b1;
        lbl_waddr = WA'(CONST_OFS) + num_in_q + WA'(g_q);
        lbl_wdata = eng_out_label;
        if (skip_tbl) begin
          // Free gates skip the stream entirely and move straight on.
          if (last_gate) begin
            state_d = DONE;
          end else begin
            g_d     = g_q + GA'(1);
            state_d = FG;
          end
        end else begin
          tbl_t0_d    = eng_t0;
          tbl_t1_d    = eng_t1;
          tbl_gid_d   = g_q;
          tbl_valid_d = 1'b1;
          state_d     = TX;
        end
      end
      TX: begin
        if (tbl_ready) begin
          tbl_valid_d = 1'b0;
          if (last_gate) begin
            state_d = DONE;
          end else begin
            g_d     = g_q + GA'(1);
            state_d = FG;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      num_gates_q <= '0;
      num_in_q    <= '0;
      cid_q       <= '0;
      logic_q     <= '0;
      eng_in0_q   <= '0;
      eng_in1_q   <= '0;
      eng_logic_q <= '0;
      eng_gid_q   <= '0;
      tbl_t0_q    <= '0;
      tbl_t1_q    <= '0;
      tbl_gid_q   <= '0;
      tbl_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      num_gates_q <= num_gates_d;
      num_in_q    <= num_in_d;
      cid_q       <= cid_d;
      logic_q     <= logic_d;
      eng_in0_q   <= eng_in0_d;
      eng_in1_q   <= eng_in1_d;
      eng_logic_q <= eng_logic_d;
      eng_gid_q   <= eng_gid_d;
      tbl_t0_q    <= tbl_t0_d;
      tbl_t1_q    <= tbl_t1_d;
      tbl_gid_q   <= tbl_gid_d;
      tbl_valid_q <= tbl_valid_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign eng_cid       = cid_q;
  assign eng_gid       = eng_gid_q;
  assign eng_g_logic   = eng_logic_q;
  assign eng_in0_label = eng_in0_q;
  assign eng_in1_label = eng_in1_q;
  assign tbl_valid     = tbl_valid_q;
  assign tbl_t0        = tbl_t0_q;
  assign tbl_t1        = tbl_t1_q;
  assign tbl_gid       = tbl_gid_q;

endmodule
